// File: rtl/bus_mux_arbiter_pkg.sv
// Shared types and constants for the bus_mux_arbiter block.
package bus_mux_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2,
    TURN   = 2'd3
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search over four requests, starting just after ptr.
module rr_pick4
  import bus_mux_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    any   = |req;
    // k=NREQ wraps back to ptr itself, so the last owner is checked last
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_mux_arbiter.sv
// Round-robin arbiter driving a dual 4:1 bus mux select with settle time before grant.
// Optional tenure limit: define BUS_MUX_ARBITER_TIMEOUT_EN to enforce MAX_HOLD.
module bus_mux_arbiter
  import bus_mux_arbiter_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int MAX_HOLD   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [SEL_W-1:0] sel,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic             timeout
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
    $error("bus_mux_arbiter: SETTLE_CYC or MAX_HOLD outside supported range");
  end

  state_t           state, state_nx;
  logic [SEL_W-1:0] sel_nx;
  logic [NREQ-1:0]  gnt_nx;
  logic [SEL_W-1:0] ptr, ptr_nx;
  logic [3:0]       settle_cnt, settle_nx;
  logic [SEL_W-1:0] winner;
  logic             any;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (winner),
    .any (any)
  );

`ifdef BUS_MUX_ARBITER_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_nx;
  logic       timeout_q, timeout_nx;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    gnt_nx    = gnt;
    ptr_nx    = ptr;
    settle_nx = settle_cnt;
`ifdef BUS_MUX_ARBITER_TIMEOUT_EN
    hold_nx    = hold_cnt;
    timeout_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        gnt_nx = '0;
        if (any) begin
          state_nx  = SETTLE;
          sel_nx    = winner;
          settle_nx = 4'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        // Requester withdrew before the mux settled: abandon without touching ptr
        if (!req[sel]) begin
          state_nx = IDLE;
        end else if (settle_cnt == 4'd0) begin
          state_nx = GRANT;
          gnt_nx   = onehot(sel);
          ptr_nx   = sel;
`ifdef BUS_MUX_ARBITER_TIMEOUT_EN
          hold_nx  = 8'd1;
`endif
        end else begin
          settle_nx = settle_cnt - 4'd1;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          state_nx = TURN;
          gnt_nx   = '0;
`ifdef BUS_MUX_ARBITER_TIMEOUT_EN
        end else if (hold_cnt == 8'(MAX_HOLD)) begin
          state_nx   = TURN;
          gnt_nx     = '0;
          timeout_nx = 1'b1;
        end else begin
          hold_nx = hold_cnt + 8'd1;
`endif
        end
      end
      TURN: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      gnt        <= '0;
      ptr        <= SEL_W'(NREQ - 1);
      settle_cnt <= '0;
`ifdef BUS_MUX_ARBITER_TIMEOUT_EN
      hold_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      gnt        <= gnt_nx;
      ptr        <= ptr_nx;
      settle_cnt <= settle_nx;
`ifdef BUS_MUX_ARBITER_TIMEOUT_EN
      hold_cnt   <= hold_nx;
      timeout_q  <= timeout_nx;
`endif
    end
  end

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Directed self-checking bench for bus_mux_arbiter (SETTLE_CYC=2, MAX_HOLD=4).
module tb_bus_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  logic [1:0] own;

  bus_mux_arbiter #(.SETTLE_CYC(2), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, then single request from source 0
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    check("rst_sel", 8'(sel), 8'd0);
    check("rst_gnt", 8'(gnt), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_timeout", 8'(timeout), 8'd0);
    rst_n = 1'b1;
    req   = 4'b0001;
    tick();
    check("first_sel", 8'(sel), 8'd0);
    check("first_busy", 8'(busy), 8'd1);
    check("first_gnt_e", 8'(gnt), 8'd0);
    tick();
    check("first_gnt_e1", 8'(gnt), 8'd0);
    tick();
    check("first_gnt_e2", 8'(gnt), 8'b0001);
    req = 4'b0000;
    tick();
    check("first_turn_gnt", 8'(gnt), 8'd0);
    check("first_turn_busy", 8'(busy), 8'd1);
    tick();
    check("first_idle_busy", 8'(busy), 8'd0);

    // Round robin with all sources requesting, fresh reset so source 0 leads
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      own = 2'(k % 4);
      tick();
      check("rr_sel", 8'(sel), 8'(own));
      check("rr_busy", 8'(busy), 8'd1);
      tick();
      check("rr_settle_gnt", 8'(gnt), 8'd0);
      tick();
      check("rr_gnt1", 8'(gnt), 8'd1 << own);
      tick();
      tick();
      check("rr_gnt3", 8'(gnt), 8'd1 << own);
      check("rr_sel_hold", 8'(sel), 8'(own));
      req[own] = 1'b0;
      tick();
      check("rr_turn_gnt", 8'(gnt), 8'd0);
      check("rr_turn_busy", 8'(busy), 8'd1);
      req = (k == 4) ? 4'b0000 : 4'b1111;
      tick();
      check("rr_idle_busy", 8'(busy), 8'd0);
    end

    // Abort during settle leaves ptr at 0
    req = 4'b0100;
    tick();
    check("abort_sel", 8'(sel), 8'd2);
    check("abort_settle_gnt", 8'(gnt), 8'd0);
    req = 4'b0000;
    tick();
    check("abort_busy", 8'(busy), 8'd0);
    check("abort_gnt", 8'(gnt), 8'd0);
    check("abort_sel_kept", 8'(sel), 8'd2);
    tick();
    check("abort_idle_gnt", 8'(gnt), 8'd0);
    req = 4'b0110;
    tick();
    check("after_abort_sel", 8'(sel), 8'd1);
    tick();
    tick();
    check("after_abort_gnt", 8'(gnt), 8'b0010);
    req = 4'b0000;
    tick();
    tick();
    check("after_abort_idle", 8'(busy), 8'd0);

`ifdef BUS_MUX_ARBITER_TIMEOUT_EN
    // ptr=1: search 2,3,0 -> source 0 wins, then is cut off after 4 cycles
    req = 4'b0011;
    tick();
    check("to_sel", 8'(sel), 8'd0);
    tick();
    tick();
    check("to_gnt_c1", 8'(gnt), 8'b0001);
    for (int c = 2; c <= 4; c++) begin
      tick();
      check("to_gnt_hold", 8'(gnt), 8'b0001);
      check("to_no_pulse", 8'(timeout), 8'd0);
    end
    tick();
    check("to_turn_gnt", 8'(gnt), 8'd0);
    check("to_pulse", 8'(timeout), 8'd1);
    tick();
    check("to_pulse_end", 8'(timeout), 8'd0);
    check("to_idle_busy", 8'(busy), 8'd0);
    tick();
    check("to_next_sel", 8'(sel), 8'd1);
    tick();
    tick();
    check("to_next_gnt", 8'(gnt), 8'b0010);
    req = 4'b0000;
    tick();
    tick();
`else
    // No tenure limit: grant held indefinitely
    req = 4'b0001;
    tick();
    check("hold_sel", 8'(sel), 8'd0);
    tick();
    tick();
    check("hold_gnt_c1", 8'(gnt), 8'b0001);
    for (int c = 0; c < 300; c++) begin
      tick();
      check("hold_gnt", 8'(gnt), 8'b0001);
      check("hold_timeout", 8'(timeout), 8'd0);
    end
    req = 4'b0000;
    tick();
    tick();
`endif

    // Asynchronous reset mid-grant
    req = 4'b1000;
    tick();
    check("ar_sel", 8'(sel), 8'd3);
    tick();
    tick();
    check("ar_gnt", 8'(gnt), 8'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_gnt_drop", 8'(gnt), 8'd0);
    check("ar_sel_zero", 8'(sel), 8'd0);
    check("ar_busy", 8'(busy), 8'd0);
    check("ar_timeout", 8'(timeout), 8'd0);
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    check("ar_first_sel", 8'(sel), 8'd0);
    tick();
    tick();
    check("ar_first_gnt", 8'(gnt), 8'b0001);
    req = 4'b0000;
    tick();
    tick();
    check("ar_final_idle", 8'(busy), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
